// File: rtl/hsv_pkg.sv
// Shared HSV stream definitions.
// Used by the color-space pipeline stages and the mask classifier.
package hsv_pkg;

    localparam int H_W     = 16;
    localparam int SV_W    = 10;
    localparam int HUE_MAX = 359;
    localparam int SV_MAX  = 255;

    typedef struct packed {
        logic signed [H_W-1:0]  h;
        logic signed [SV_W-1:0] s;
        logic signed [SV_W-1:0] v;
        logic                   sof;
        logic                   eof;
    } hsv_pixel;

    typedef struct packed {
        logic mask;
        logic sof;
        logic eof;
    } mask_pixel;

endpackage

// File: rtl/hsv_range_cmp.sv
// Combinational HSV window test.
// The hue window wraps through 0 when h_lo > h_hi.
module hsv_range_cmp #(
    parameter int H_W  = 16,
    parameter int SV_W = 10
) (
    input  logic signed [H_W-1:0]  h,
    input  logic signed [H_W-1:0]  h_lo,
    input  logic signed [H_W-1:0]  h_hi,
    input  logic signed [SV_W-1:0] s,
    input  logic signed [SV_W-1:0] s_min,
    input  logic signed [SV_W-1:0] s_max,
    input  logic signed [SV_W-1:0] v,
    input  logic signed [SV_W-1:0] v_min,
    input  logic signed [SV_W-1:0] v_max,
    output logic                   match
);
    import hsv_pkg::*;

    localparam logic signed [H_W-1:0] H_ZERO = '0;
    localparam logic signed [H_W-1:0] H_TOP  = H_W'(HUE_MAX);

    logic h_legal;
    logic h_ok;
    logic s_ok;
    logic v_ok;

    always_comb begin
        h_legal = (h >= H_ZERO) && (h <= H_TOP);
        if (h_lo <= h_hi) begin
            h_ok = (h_lo <= h) && (h <= h_hi);
        end else begin
            h_ok = (h >= h_lo) || (h <= h_hi);
        end
        s_ok  = (s_min <= s) && (s <= s_max);
        v_ok  = (v_min <= v) && (v <= v_max);
        match = h_legal && h_ok && s_ok && v_ok;
    end

endmodule

// File: rtl/hsv_color_mask.sv
// HSV window classifier: two-stage compare/count pipeline
// producing a binary mask stream and a per-frame match area.
module hsv_color_mask #(
    parameter int H_W   = 16,
    parameter int SV_W  = 10,
    parameter int CNT_W = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [H_W-1:0]  in_h,
    input  logic signed [SV_W-1:0] in_s,
    input  logic signed [SV_W-1:0] in_v,
    input  logic                   in_sof,
    input  logic                   in_eof,
    input  logic signed [H_W-1:0]  cfg_h_lo,
    input  logic signed [H_W-1:0]  cfg_h_hi,
    input  logic signed [SV_W-1:0] cfg_s_min,
    input  logic signed [SV_W-1:0] cfg_v_min,
    input  logic signed [SV_W-1:0] cfg_s_max,
    input  logic signed [SV_W-1:0] cfg_v_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mask,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [CNT_W-1:0]       frame_count,
    output logic                   frame_count_valid
);
    import hsv_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic signed [H_W-1:0]  sh_h_lo, sh_h_hi;
    logic signed [SV_W-1:0] sh_s_min, sh_s_max;
    logic signed [SV_W-1:0] sh_v_min, sh_v_max;

    logic signed [H_W-1:0]  use_h_lo, use_h_hi;
    logic signed [SV_W-1:0] use_s_min, use_s_max;
    logic signed [SV_W-1:0] use_v_min, use_v_max;

    logic       en1, en2, accept, hit;
    logic       s1_valid, s2_valid;
    mask_pixel  s1_pix, s2_pix;
    logic [CNT_W-1:0] count, count_next;

    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;
    assign accept   = in_valid && en1;

    // A start-of-frame pixel is judged by the window it installs.
    assign use_h_lo  = in_sof ? cfg_h_lo  : sh_h_lo;
    assign use_h_hi  = in_sof ? cfg_h_hi  : sh_h_hi;
    assign use_s_min = in_sof ? cfg_s_min : sh_s_min;
    assign use_s_max = in_sof ? cfg_s_max : sh_s_max;
    assign use_v_min = in_sof ? cfg_v_min : sh_v_min;
    assign use_v_max = in_sof ? cfg_v_max : sh_v_max;

    hsv_range_cmp #(.H_W(H_W), .SV_W(SV_W)) u_cmp (
        .h     (in_h),
        .h_lo  (use_h_lo),
        .h_hi  (use_h_hi),
        .s     (in_s),
        .s_min (use_s_min),
        .s_max (use_s_max),
        .v     (in_v),
        .v_min (use_v_min),
        .v_max (use_v_max),
        .match (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            sh_h_lo  <= '0;
            sh_h_hi  <= '0;
            sh_s_min <= '0;
            sh_s_max <= '0;
            sh_v_min <= '0;
            sh_v_max <= '0;
        end else begin
            if (en1) s1_valid <= in_valid;
            if (accept) begin
                s1_pix <= '{mask: hit, sof: in_sof, eof: in_eof};
            end
            if (accept && in_sof) begin
                sh_h_lo  <= cfg_h_lo;
                sh_h_hi  <= cfg_h_hi;
                sh_s_min <= cfg_s_min;
                sh_s_max <= cfg_s_max;
                sh_v_min <= cfg_v_min;
                sh_v_max <= cfg_v_max;
            end
        end
    end

    always_comb begin
        count_next = count;
        if (s1_pix.sof) begin
            count_next = CNT_W'(s1_pix.mask);
        end else if (s1_pix.mask && count != CNT_MAX) begin
            count_next = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid          <= 1'b0;
            s2_pix            <= '0;
            count             <= '0;
            frame_count       <= '0;
            frame_count_valid <= 1'b0;
        end else begin
            if (en2) s2_valid <= s1_valid;
            if (s1_valid && en2) begin
                s2_pix <= s1_pix;
                count  <= count_next;
                if (s1_pix.eof) frame_count <= count_next;
            end
            frame_count_valid <= s1_valid && en2 && s1_pix.eof;
        end
    end

    assign out_valid = s2_valid;
    assign out_mask  = s2_pix.mask;
    assign out_sof   = s2_pix.sof;
    assign out_eof   = s2_pix.eof;

endmodule

// File: tb/tb_hsv_color_mask.sv
// Bench for hsv_color_mask: directed steps plus random frames
// scored against an arithmetic reference of the window rules.
module tb_hsv_color_mask;

    localparam int H_W     = 16;
    localparam int SV_W    = 10;
    localparam int CNT_W   = 20;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [H_W-1:0]  in_h = '0;
    logic signed [SV_W-1:0] in_s = '0;
    logic signed [SV_W-1:0] in_v = '0;
    logic                   in_sof = 1'b0;
    logic                   in_eof = 1'b0;
    logic signed [H_W-1:0]  cfg_h_lo, cfg_h_hi;
    logic signed [SV_W-1:0] cfg_s_min, cfg_s_max, cfg_v_min, cfg_v_max;
    logic                   out_valid, out_ready, out_mask, out_sof, out_eof;
    logic [CNT_W-1:0]       frame_count;
    logic                   frame_count_valid;

    int c_hlo = 0, c_hhi = 0, c_smin = 0, c_smax = 0, c_vmin = 0, c_vmax = 0;
    logic man_rdy = 1'b1;
    logic rand_bp = 1'b0;
    logic rnd_rdy = 1'b1;

    assign cfg_h_lo  = c_hlo[H_W-1:0];
    assign cfg_h_hi  = c_hhi[H_W-1:0];
    assign cfg_s_min = c_smin[SV_W-1:0];
    assign cfg_s_max = c_smax[SV_W-1:0];
    assign cfg_v_min = c_vmin[SV_W-1:0];
    assign cfg_v_max = c_vmax[SV_W-1:0];
    assign out_ready = rand_bp ? rnd_rdy : man_rdy;

    always #5 clk = ~clk;
    always @(negedge clk) rnd_rdy = ($urandom_range(0, 2) != 0);

    hsv_color_mask #(.H_W(H_W), .SV_W(SV_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_h              (in_h),
        .in_s              (in_s),
        .in_v              (in_v),
        .in_sof            (in_sof),
        .in_eof            (in_eof),
        .cfg_h_lo          (cfg_h_lo),
        .cfg_h_hi          (cfg_h_hi),
        .cfg_s_min         (cfg_s_min),
        .cfg_v_min         (cfg_v_min),
        .cfg_s_max         (cfg_s_max),
        .cfg_v_max         (cfg_v_max),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_mask          (out_mask),
        .out_sof           (out_sof),
        .out_eof           (out_eof),
        .frame_count       (frame_count),
        .frame_count_valid (frame_count_valid)
    );

    typedef struct {
        bit mask;
        bit sof;
        bit eof;
    } exp_t;

    exp_t exp_q[$];
    int   fc_q[$];
    bit   obs_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   last_fc = -1;

    // reference state: the window latched by the last sof and the running area
    int m_hlo = 0, m_hhi = 0, m_smin = 0, m_smax = 0, m_vmin = 0, m_vmax = 0;
    int m_cnt = 0;

    function automatic bit ref_mask(int h, int s, int v);
        bit hue;
        if (h < 0 || h > 359) hue = 0;
        else if (m_hlo <= m_hhi) hue = (h >= m_hlo && h <= m_hhi);
        else hue = !(h > m_hhi && h < m_hlo);
        return hue && s >= m_smin && s <= m_smax && v >= m_vmin && v <= m_vmax;
    endfunction

    task automatic model_accept(int h, int s, int v, bit sof, bit eof);
        bit m;
        exp_t e;
        if (sof) begin
            m_hlo = c_hlo; m_hhi = c_hhi;
            m_smin = c_smin; m_smax = c_smax;
            m_vmin = c_vmin; m_vmax = c_vmax;
        end
        m = ref_mask(h, s, v);
        if (sof) m_cnt = int'(m);
        else if (m_cnt < CNT_MAX) m_cnt += int'(m);
        if (eof) fc_q.push_back(m_cnt);
        e.mask = m; e.sof = sof; e.eof = eof;
        exp_q.push_back(e);
    endtask

    task automatic send(int h, int s, int v, bit sof, bit eof);
        bit done = 0;
        @(negedge clk);
        in_h = h[H_W-1:0]; in_s = s[SV_W-1:0]; in_v = v[SV_W-1:0];
        in_sof = sof; in_eof = eof; in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            #1;
            if (in_ready) begin
                model_accept(h, s, v, sof, eof);
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        checks++;
        assert (done === 1'b1) else begin
            failures++;
            $error("FAIL send_timeout accepted=%0d required=1", done);
        end
    endtask

    task automatic drain();
        bit empty = 0;
        for (int t = 0; t < 3000 && !empty; t++) begin
            @(negedge clk);
            #2;
            empty = (exp_q.size() == 0);
        end
        repeat (2) @(negedge clk);
        checks++;
        assert (empty === 1'b1) else begin
            failures++;
            $error("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    task automatic check_bit(string tag, logic got, logic want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, want);
        end
    endtask

    task automatic check_int(string tag, int got, int want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                exp_t e;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_pixel got=%b exp=none", out_mask);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert ({out_mask, out_sof, out_eof} === {e.mask, e.sof, e.eof}) else begin
                        failures++;
                        $error("FAIL pixel got=%b%b%b exp=%b%b%b",
                               out_mask, out_sof, out_eof, e.mask, e.sof, e.eof);
                    end
                end
                obs_q.push_back(out_mask);
            end
            if (frame_count_valid) begin
                int ef;
                pulses++;
                last_fc = int'(frame_count);
                checks++;
                assert (fc_q.size() != 0) else begin
                    failures++;
                    $error("FAIL extra_pulse got=%0d exp=none", frame_count);
                end
                if (fc_q.size() != 0) begin
                    ef = fc_q.pop_front();
                    checks++;
                    assert (int'(frame_count) === ef) else begin
                        failures++;
                        $error("FAIL frame_count got=%0d exp=%0d", frame_count, ef);
                    end
                end
            end
        end
    end

    task automatic set_cfg(int hlo, int hhi, int smin, int smax, int vmin, int vmax);
        c_hlo = hlo; c_hhi = hhi; c_smin = smin;
        c_smax = smax; c_vmin = vmin; c_vmax = vmax;
    endtask

    initial begin
        int p0;
        int len;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_out_mask", out_mask, 1'b0);
        check_bit("rst_out_sof", out_sof, 1'b0);
        check_bit("rst_out_eof", out_eof, 1'b0);
        check_bit("rst_fc_valid", frame_count_valid, 1'b0);
        check_int("rst_frame_count", int'(frame_count), 0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // zero shadow window before any sof
        obs_q.delete();
        send(0, 0, 0, 0, 0);
        send(5, 0, 0, 0, 0);
        drain();
        check_int("presof_n", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check_bit("presof_zero", obs_q[0], 1'b1);
            check_bit("presof_h5", obs_q[1], 1'b0);
        end

        // two-cycle latency on a sof pixel
        set_cfg(100, 140, 50, 255, 50, 255);
        send(120, 128, 80, 1, 0);
        @(negedge clk); #1;
        check_bit("lat_c1_valid", out_valid, 1'b0);
        @(negedge clk); #1;
        check_bit("lat_c2_valid", out_valid, 1'b1);
        check_bit("lat_c2_mask", out_mask, 1'b1);
        check_bit("lat_c2_sof", out_sof, 1'b1);
        send(120, 128, 80, 0, 1);
        drain();

        // wrap-around hue window
        set_cfg(340, 20, 0, 255, 0, 255);
        obs_q.delete();
        send(350, 100, 100, 1, 0);
        send(10, 100, 100, 0, 0);
        send(20, 100, 100, 0, 0);
        send(21, 100, 100, 0, 0);
        send(339, 100, 100, 0, 1);
        drain();
        check_int("wrap_n", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            check_bit("wrap_350", obs_q[0], 1'b1);
            check_bit("wrap_10", obs_q[1], 1'b1);
            check_bit("wrap_20", obs_q[2], 1'b1);
            check_bit("wrap_21", obs_q[3], 1'b0);
            check_bit("wrap_339", obs_q[4], 1'b0);
        end

        // illegal hues, even inside a wrapped window
        obs_q.delete();
        send(-1, 100, 100, 1, 0);
        send(360, 100, 100, 0, 1);
        drain();
        check_int("hrange_n", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check_bit("hrange_m1", obs_q[0], 1'b0);
            check_bit("hrange_360", obs_q[1], 1'b0);
        end

        // backpressure mid-stream
        set_cfg(0, 359, 0, 255, 128, 255);
        obs_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(50, 100, (i % 2 == 0) ? 200 : 50, i == 0, i == 7);
            end
            begin
                repeat (3) @(negedge clk);
                man_rdy = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                check_bit("bp_in_ready", in_ready, 1'b0);
                @(negedge clk);
                man_rdy = 1'b1;
            end
        join
        drain();
        check_int("bp_n", obs_q.size(), 8);
        for (int i = 0; i < obs_q.size(); i++)
            check_bit("bp_seq", obs_q[i], (i % 2 == 0));

        // frame area: 4 of 10, then 0 of 5
        set_cfg(0, 359, 0, 255, 100, 255);
        p0 = pulses;
        for (int i = 0; i < 10; i++)
            send(30, 30, (i == 1 || i == 3 || i == 6 || i == 9) ? 150 : 20, i == 0, i == 9);
        drain();
        check_int("fc4_pulses", pulses - p0, 1);
        check_int("fc4_value", last_fc, 4);
        for (int i = 0; i < 5; i++)
            send(30, 30, 20, i == 0, i == 4);
        drain();
        check_int("fc0_pulses", pulses - p0, 2);
        check_int("fc0_value", last_fc, 0);

        // config edits only take hold at the next sof
        set_cfg(0, 359, 50, 255, 0, 255);
        obs_q.delete();
        send(10, 10, 100, 1, 0);
        c_smin = 0;
        send(10, 10, 100, 0, 1);
        send(10, 10, 100, 1, 1);
        drain();
        check_int("cfg_n", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check_bit("cfg_old0", obs_q[0], 1'b0);
            check_bit("cfg_old1", obs_q[1], 1'b0);
            check_bit("cfg_new", obs_q[2], 1'b1);
        end

        // random frames under random backpressure
        rand_bp = 1'b1;
        for (int f = 0; f < 40; f++) begin
            set_cfg($urandom_range(0, 359), $urandom_range(0, 359),
                    $urandom_range(0, 150), $urandom_range(100, 255),
                    $urandom_range(0, 150), $urandom_range(100, 255));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if (i == len / 2 && $urandom_range(0, 3) == 0) c_smin = 0;
                send(int'($urandom_range(0, 370)) - 5,
                     int'($urandom_range(0, 262)) - 3,
                     int'($urandom_range(0, 262)) - 3,
                     (i == 0) && ($urandom_range(0, 7) != 0),
                     (i == len - 1) && ($urandom_range(0, 7) != 0));
            end
        end
        drain();
        rand_bp = 1'b0;

        // reset with pixels in flight
        man_rdy = 1'b0;
        p0 = pulses;
        set_cfg(0, 359, 0, 255, 0, 255);
        send(1, 1, 1, 1, 0);
        send(2, 2, 2, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_valid", out_valid, 1'b0);
        check_bit("mid_rst_pulse", frame_count_valid, 1'b0);
        exp_q.delete();
        m_cnt = 0;
        m_hlo = 0; m_hhi = 0; m_smin = 0; m_smax = 0; m_vmin = 0; m_vmax = 0;
        @(negedge clk);
        rst_n = 1'b1;
        man_rdy = 1'b1;
        send(0, 0, 0, 0, 1);
        drain();
        check_int("post_rst_pulses", pulses - p0, 1);
        check_int("post_rst_fc", last_fc, 1);

        check_int("left_pixels", exp_q.size(), 0);
        check_int("left_frames", fc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hsv_color_mask.md
Name: hsv_color_mask

Overview:
- Streaming consumer of the RGB-to-HSV pipeline output (H, S, V per pixel).
- Classifies each pixel against programmable HSV windows and emits a 1-bit mask pixel stream.
- Counts matching pixels per frame, giving downstream object-detection logic a binary image plus area statistic.
- Sits directly downstream of the s8 hue stage and the V/S taps.

Parameters:
- H_W, 16, width of signed hue input (degrees, valid 0..359)
- SV_W, 10, width of signed S and V inputs (valid 0..255)
- CNT_W, 20, width of per-frame match counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept pixel
- in_h  in  H_W  hue, signed
- in_s  in  SV_W  saturation, signed
- in_v  in  SV_W  value, signed
- in_sof  in  1  first pixel of frame
- in_eof  in  1  last pixel of frame
- cfg_h_lo, cfg_h_hi  in  H_W  hue window bounds
- cfg_s_min, cfg_v_min  in  SV_W  lower bounds, inclusive
- cfg_s_max, cfg_v_max  in  SV_W  upper bounds, inclusive
- out_valid  out  1  mask pixel valid
- out_ready  in  1  downstream accepts
- out_mask  out  1  1 = pixel inside window
- out_sof, out_eof  out  1  frame markers, aligned with out_mask
- frame_count  out  CNT_W  matched pixels of last completed frame
- frame_count_valid  out  1  one-cycle pulse when frame_count updates

Behaviour:
- Clock and reset: one clock domain (clk). Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; in_ready is 1 after reset; internal stage valids 0; shadow config 0; counter 0.
- Handshake:
  - Transfer on valid&&ready at either side.
  - in_valid and data held stable by upstream until accepted; out_* held stable while out_valid && !out_ready.
- Pipeline: two registered stages, S1 = compare, S2 = output/count.
  - en2 = !s2_valid || out_ready.
  - en1 = !s1_valid || en2.
  - in_ready = en1.
  - Latency 2 cycles from accept to out_valid with no stall.
  - Throughput 1 pixel/cycle.
  - No pixel dropped or duplicated under any out_ready pattern.
- Config shadowing:
  - cfg_* copied to shadow registers on acceptance of a pixel with in_sof=1; that pixel already uses the new values.
  - Before the first sof, shadow = reset values (all 0), so mask = 1 only for H=S=V=0.
- S1 compare, signed arithmetic throughout:
  - h_ok = (h_lo <= h_hi) ? (h_lo <= H && H <= h_hi) : (H >= h_lo || H <= h_hi). The second form is the hue wrap-around window, e.g. 340..20.
  - s_ok = s_min <= S <= s_max.
  - v_ok = v_min <= V <= v_max.
  - H < 0 or H > 359 forces h_ok = 0.
  - mask = h_ok & s_ok & v_ok.
- S2 counter (advances on S1->S2 transfer):
  - Pixel with sof: counter loads mask (0 or 1).
  - Otherwise: counter += mask, saturating at 2^CNT_W-1.
  - Pixel with eof: frame_count <= updated count; frame_count_valid pulses one cycle on the cycle that pixel enters S2.
  - Pixel with sof and eof together (1-pixel frame): count = mask, pulse issued.
  - eof without a preceding sof: counter continues from its current value.
  - sof mid-frame (missing eof): counter restarts, no pulse.
- Reset asserted mid-frame: pipeline flushed, in-flight pixels lost, no frame_count pulse.

Decomposition:
- Shared package hsv_pkg:
  - HUE_MAX=359, SV_MAX=255 constants.
  - H_W, SV_W widths.
  - hsv_pixel struct {h,s,v,sof,eof}, reused by the upstream pipeline stages.
- One natural sub-module: hsv_range_cmp (combinational window compare including hue wrap), instantiated once in S1.

Test Plan:
- Reset then cfg h 100..140, s 50..255, v 50..255, sof pixel (120,128,80), out_ready=1 -> out_valid at cycle+2, out_mask=1, out_sof=1.
- Wrap window h_lo=340 h_hi=20: pixels H=350, 10, 20, 21, 339 -> masks 1,1,1,0,0.
- Out-of-range H=-1 and H=360 with full S/V windows -> mask 0 both.
- Backpressure:
  - Stream 8 pixels.
  - Drive out_ready low for 3 cycles mid-stream.
  - Expected: in_ready drops within 1 cycle once both stages full.
  - Expected: output sequence identical and unduplicated.
- Frame of 10 pixels with 4 matching, eof on last -> frame_count=4, single frame_count_valid pulse; next frame with 0 matches -> frame_count=0.
- Config change mid-frame (widen s window) -> no effect until next sof pixel, which uses new window.
